// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding, blank code, digit-select helper.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam logic [7:0] SEG_BLANK_CODE = 8'hFF;

  // One-hot digit select (or all-inactive when on=0), with selectable polarity
  function automatic logic [MAX_DIGITS-1:0] sel_vec(input logic on, input logic [2:0] idx,
                                                    input logic active_low);
    logic [MAX_DIGITS-1:0] v;
    v = on ? (MAX_DIGITS'(1) << idx) : '0;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter timing one SHOW or BLANK slot; tc_c flags the last cycle of the slot.
module seg7_slot_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc_c = (cnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-seg scan controller with shadowed frame updates and inter-digit blanking.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIV            = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter int unsigned ACTIVE_LOW_SEL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [7:0]              dig_val,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      SHOW_LOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic                  SEL_POL    = (ACTIVE_LOW_SEL != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE   = NUM_DIGITS'(sel_vec(1'b0, 3'd0, SEL_POL));

  logic [1:0]            state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val, cnt, cnt_nx;
  logic                  tc_c;
  logic [DATA_W-1:0]     active, active_nx, shadow, shadow_nx;
  logic                  pending_nx;
  logic [3:0]            nib;
  logic                  lzb;
  logic [7:0]            dig_val_nx;
  logic [NUM_DIGITS-1:0] digit_sel_nx;
  logic                  frame_done_nx;

  seg7_slot_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (cnt),
    .tc_c     (tc_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_OFF;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Scan sequencing: each slot ends on the timer's terminal count
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!enable) begin
      state_nx = S_OFF;
      idx_nx   = '0;
      tmr_load = 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          state_nx = S_SHOW;
          idx_nx   = '0;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
        end
        S_SHOW: begin
          if (tc_c) begin
            state_nx = S_BLANK;
            tmr_load = 1'b1;
            tmr_val  = BLANK_LOAD;
          end
        end
        S_BLANK: begin
          if (tc_c) begin
            state_nx = S_SHOW;
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            tmr_load = 1'b1;
            tmr_val  = SHOW_LOAD;
          end
        end
        default: begin
          state_nx = S_OFF;
          idx_nx   = '0;
          tmr_load = 1'b1;
        end
      endcase
    end
    cnt_nx = tmr_load ? tmr_val : (tc_c ? '0 : cnt - CNT_W'(1));
  end

  // Frame data: loads land in shadow and are promoted only at the frame boundary or while off
  always_comb begin
    active_nx  = active;
    shadow_nx  = shadow;
    pending_nx = pending;
    if (load) begin
      shadow_nx = digits_in;
      if (state == S_OFF || frame_done) begin
        active_nx  = digits_in;
        pending_nx = 1'b0;
      end else begin
        pending_nx = 1'b1;
      end
    end else if (pending && (frame_done || (state == S_OFF && enable))) begin
      active_nx  = shadow;
      pending_nx = 1'b0;
    end
  end

  always_comb begin
    nib = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_nx == IDX_W'(i)) nib = active_nx[4*i +: 4];
    end
  end

`ifdef SEG7_LZB_EN
  logic zacc;
  // A digit is suppressed when it and every more-significant nibble are zero; digit 0 never is
  always_comb begin
    zacc = 1'b1;
    lzb  = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zacc = zacc & (active_nx[4*i +: 4] == 4'h0);
      if (i != 0 && idx_nx == IDX_W'(i)) lzb = zacc;
    end
  end
`else
  assign lzb = 1'b0;
`endif

  always_comb begin
    dig_val_nx    = SEG_BLANK_CODE;
    digit_sel_nx  = SEL_IDLE;
    frame_done_nx = (state_nx == S_BLANK) && (idx_nx == IDX_LAST) && (cnt_nx == '0);
    if (state_nx == S_SHOW) begin
      dig_val_nx   = lzb ? SEG_BLANK_CODE : {4'h0, nib};
      digit_sel_nx = NUM_DIGITS'(sel_vec(1'b1, 3'(idx_nx), SEL_POL));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      dig_val    <= SEG_BLANK_CODE;
      digit_sel  <= SEL_IDLE;
      frame_done <= 1'b0;
    end else begin
      active     <= active_nx;
      shadow     <= shadow_nx;
      pending    <= pending_nx;
      dig_val    <= dig_val_nx;
      digit_sel  <= digit_sel_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-position model predicts every output cycle.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIVC  = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = DIVC + BLK;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [7:0]  dig_val;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        pending;

  typedef struct packed {
    logic [7:0] val;
    logic [3:0] sel;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_err    = 0;

  // Model: t = cycles since scanning started (-1 when dark)
  int          t;
  logic [15:0] m_active, m_shadow;
  logic        m_pending;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND), .DIV(DIVC), .BLANK_CYC(BLK), .ACTIVE_LOW_SEL(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .dig_val    (dig_val),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] digit_value(input logic [15:0] a, input int d);
    logic [3:0] n;
    n = a[4*d +: 4];
`ifdef SEG7_LZB_EN
    if (d > 0 && (a >> (4*d)) == 16'h0) return 8'hFF;
`endif
    return {4'h0, n};
  endfunction

  function automatic exp_t predict();
    exp_t       e;
    int         pos, d;
    logic [3:0] oh;
    e.pend = m_pending;
    if (t < 0) begin
      e.val = 8'hFF;
      e.sel = 4'hF;
      e.fd  = 1'b0;
    end else begin
      pos  = t % FRAME;
      d    = pos / SLOT;
      oh   = 4'b0001 << d;
      e.fd = (pos == FRAME - 1);
      if ((pos % SLOT) < DIVC) begin
        e.val = digit_value(m_active, d);
        e.sel = ~oh;
      end else begin
        e.val = 8'hFF;
        e.sel = 4'hF;
      end
    end
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge
  task automatic step(input logic en, input logic ld, input logic [15:0] din);
    logic fd_now;
    @(negedge clk);
    enable    = en;
    load      = ld;
    digits_in = din;
    fd_now = (t >= 0) && ((t % FRAME) == FRAME - 1);
    if (ld) begin
      m_shadow = din;
      if (t < 0 || fd_now) begin
        m_active  = din;
        m_pending = 1'b0;
      end else begin
        m_pending = 1'b1;
      end
    end else if (m_pending && (fd_now || (t < 0 && en))) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    t = en ? t + 1 : -1;
    exp_q.push_back(predict());
  endtask

  task automatic run_to(input int pos);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (t >= 0 && (t % FRAME) == pos) break;
      step(1'b1, 1'b0, 16'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    #1;
    check("rst_dig_val", dig_val, 8'hFF);
    check("rst_digit_sel", digit_sel, 4'hF);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_pending", pending, 1'b0);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    t         = -1;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("dig_val", dig_val, mon_e.val);
        check("digit_sel", digit_sel, mon_e.sel);
        check("frame_done", frame_done, mon_e.fd);
        check("pending", pending, mon_e.pend);
      end
    end
  end

  initial begin
    logic [15:0] din;
    rst       = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    t         = -1;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_dig_val", dig_val, 8'hFF);
    check("init_digit_sel", digit_sel, 4'hF);
    check("init_frame_done", frame_done, 1'b0);
    check("init_pending", pending, 1'b0);
    #1;
    rst = 1'b1;

    // Load while off and start scanning in the same cycle
    step(1'b1, 1'b1, 16'h1234);
    repeat (7) step(1'b1, 1'b0, 16'h0);
    // Mid-frame load during digit 1: held pending until the boundary
    step(1'b1, 1'b1, 16'h5678);
    repeat (2 * FRAME) step(1'b1, 1'b0, 16'h0);
    // Load coincident with the frame_done cycle
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 16'h9ABC);
    repeat (FRAME) step(1'b1, 1'b0, 16'h0);
    // Disable during digit 2 SHOW, then re-enable
    run_to(2 * SLOT);
    step(1'b0, 1'b0, 16'h0);
    repeat (3) step(1'b0, 1'b0, 16'h0);
    repeat (FRAME + 3) step(1'b1, 1'b0, 16'h0);
    // Leading-zero patterns loaded while off
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h00A7);
    repeat (FRAME + 1) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0000);
    repeat (FRAME + 1) step(1'b1, 1'b0, 16'h0);
    // Asynchronous reset during digit 1 SHOW with a frame pending
    run_to(SLOT);
    step(1'b1, 1'b1, 16'h4321);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      din = 16'($urandom);
      case ($urandom_range(0, 3))
        0: din = din & 16'h000F;
        1: din = din & 16'h00FF;
        2: din = din & 16'h0FFF;
        default: ;
      endcase
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0), din);
      end
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
